// File: rtl/pulse_gen_pkg.sv
// Shared state type, default phase lengths and timer sizing for pulse_train_gen.
package pulse_gen_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} pg_state_t;

  localparam int unsigned PG_HIGH_CYC = 4;
  localparam int unsigned PG_LOW_CYC  = 4;

  // Width that can hold the larger phase length minus one.
  function automatic int unsigned pg_timer_width(int unsigned high_cyc, int unsigned low_cyc);
    int unsigned m;
    m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request/status bundle for pulse_train_gen; abort exists only with PULSE_TRAIN_GEN_ABORT_EN.
interface pulse_train_gen_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] count;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic         abort;
`endif
  logic         pulse_out;
  logic         busy;
  logic         done;
  logic [N-1:0] pulses_sent;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  modport master (
    output start, count, abort,
    input  pulse_out, busy, done, pulses_sent
  );
  modport slave (
    input  start, count, abort,
    output pulse_out, busy, done, pulses_sent
  );
`else
  modport master (
    output start, count,
    input  pulse_out, busy, done, pulses_sent
  );
  modport slave (
    input  start, count,
    output pulse_out, busy, done, pulses_sent
  );
`endif

endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module phase_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits a burst of fixed-width pulses on request; optional early abort via
// PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned HIGH_CYC = PG_HIGH_CYC,
  parameter int unsigned LOW_CYC  = PG_LOW_CYC
) (
  input logic               clk,
  input logic               rst,
  pulse_train_gen_if.slave  bus
);

  localparam int unsigned TW = pg_timer_width(HIGH_CYC, LOW_CYC);
  localparam logic [TW-1:0] HighLoad = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] LowLoad  = TW'(LOW_CYC - 1);

  pg_state_t    state_q;
  logic         pulse_q, busy_q, done_q;
  logic [N-1:0] sent_q, cnt_q;
  logic         timer_load, timer_exp, end_burst;
  logic [TW-1:0] timer_val;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic         abort_q;
`endif

  // A high phase is the last one when the requested count is reached or an abort is pending.
  always_comb begin
    end_burst = (sent_q == cnt_q);
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    end_burst = end_burst || abort_q || bus.abort;
`endif
  end

  always_comb begin
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.count != '0)) begin
          timer_load = 1'b1;
          timer_val  = HighLoad;
        end
      end
      HIGH: begin
        if (timer_exp && !end_burst) begin
          timer_load = 1'b1;
          timer_val  = LowLoad;
        end
      end
      LOW: begin
        if (timer_exp) begin
          timer_load = 1'b1;
          timer_val  = HighLoad;
        end
      end
      default: ;
    endcase
  end

  phase_timer #(
    .Width (TW)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .expired_o  (timer_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
      cnt_q   <= '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
`ifdef PULSE_TRAIN_GEN_ABORT_EN
            abort_q <= 1'b0;
`endif
            if (bus.count != '0) begin
              // First rising edge goes out on this same clock edge.
              state_q <= HIGH;
              cnt_q   <= bus.count;
              sent_q  <= N'(1);
              pulse_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= FIN;
              cnt_q   <= '0;
              sent_q  <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        HIGH: begin
`ifdef PULSE_TRAIN_GEN_ABORT_EN
          if (bus.abort) abort_q <= 1'b1;
`endif
          if (timer_exp) begin
            pulse_q <= 1'b0;
            if (end_burst) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOW;
            end
          end
        end
        LOW: begin
`ifdef PULSE_TRAIN_GEN_ABORT_EN
          if (bus.abort) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else
`endif
          if (timer_exp) begin
            state_q <= HIGH;
            pulse_q <= 1'b1;
            sent_q  <= sent_q + N'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_sent = sent_q;

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Transmit-side counterpart of the input capture chain (synchronizer, rising-edge detector, counter).
- On a start request, emits a programmable number of clean, fixed-width pulses on one output pin.
- The output can drive the board-level LM555 input path, or loop back internally, to exercise the capture chain with a known pulse count.
- Sits in the clk_out1 domain of the clocking wizard.

Parameters:
- N, 8, width of the pulse-count request and of the sent-pulse counter
- HIGH_CYC, 4, clk cycles pulse_out stays high per pulse (legal ≥ 3, so a 2-flop synchronizer plus edge detector always catches it)
- LOW_CYC, 4, clk cycles pulse_out stays low between pulses (legal ≥ 3)

Ports:
- clk  input  1  system clock (clk_out1)
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a burst; sampled only in IDLE
- count  input  N  number of pulses in the burst; captured on the accepted start
- pulse_out  output  1  generated pulse train, registered
- busy  output  1  high from the cycle after an accepted start until the cycle done asserts
- done  output  1  single-cycle strobe at end of burst
- pulses_sent  output  N  rising edges emitted in the current/last burst; holds its value after done

Behaviour:
- Reset (rst=0, async): state=IDLE, pulse_out=0, busy=0, done=0, pulses_sent=0, internal timers and latched count=0.
  - Release is synchronous to the next clk edge via the top-level synchronizer; the block only requires an async assert.
- States: IDLE, HIGH, LOW, FIN.
- IDLE:
  - start=1 with count≠0 → HIGH. Latch count, clear pulses_sent, load phase timer with HIGH_CYC-1.
  - pulse_out rises on the same edge: latency of 1 clk from start sampled to pulse_out=1.
  - start=1 with count=0 → FIN. No pulse is emitted and pulses_sent is cleared to 0.
- HIGH:
  - pulse_out=1 for exactly HIGH_CYC cycles.
  - pulses_sent increments on the HIGH entry edge, so it counts rising edges.
  - Timer expiry with pulses_sent==latched count → FIN. No trailing LOW phase.
  - Otherwise timer expiry → LOW, with timer loaded to LOW_CYC-1.
- LOW: pulse_out=0 for exactly LOW_CYC cycles, then → HIGH.
- FIN: pulse_out=0, busy=0, done=1 for one cycle, then → IDLE.
- busy:
  - Equals 1 in HIGH and LOW, 0 in IDLE and FIN.
  - start while busy or in FIN is ignored; no queuing.
- count changes after acceptance have no effect on the running burst.
- Burst with count=K ≠ 0:
  - Total duration from start to done is K·HIGH_CYC + (K-1)·LOW_CYC + 1 cycles.
  - count=2^N-1 (255) must complete with pulses_sent=255 and no wrap.
- Timers are sized $clog2(max(HIGH_CYC,LOW_CYC)); the pulse counter is N bits. No arithmetic overflow is permitted.
- Reset asserted mid-burst: pulse_out drops to 0 asynchronously, with no glitch back high. Outputs return to reset values and done is not asserted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro PULSE_TRAIN_GEN_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOW → FIN on the next edge.
  - abort=1 in HIGH → the current high phase completes its full HIGH_CYC (no runt pulse), then → FIN.
  - Ignored in IDLE and FIN.
  - pulses_sent reports the pulses actually emitted.
- Not defined: the port does not exist, and every burst runs to completion.

Decomposition:
- Package pulse_gen_pkg holds:
  - typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} pg_state_t
  - default constants PG_HIGH_CYC=4 and PG_LOW_CYC=4
- One sub-module, phase_timer: a loadable down-counter with expire flag, instanced once and reloaded per phase.
- The FSM and pulse counter stay in the top.

Test Plan:
- Reset, then start with count=3, HIGH_CYC=LOW_CYC=4 → 3 pulses each 4 cycles high, gaps 4 cycles, done at cycle 21 after start, pulses_sent=3.
- start with count=0 → no pulse_out activity, done one cycle later (cycle 2), pulses_sent=0, busy never 1.
- start with count=5, pulse start again at pulses 2 and 4 with count=9 → ignored; exactly 5 pulses, pulses_sent=5.
- Loopback through Sincronizador + detector_flanco + Contador with count=255 → counter reads 8'hFF at done, pulses_sent=255.
- Assert rst during the 2nd high phase of count=4 → pulse_out=0 in the same timestep, all outputs at reset values, no done; new start with count=1 works.
- (ABORT_EN) count=10, abort mid-HIGH of pulse 3 → pulse 3 full width, done follows, pulses_sent=3; abort in LOW after pulse 6 → done next cycle, pulses_sent=6.
